// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writeback requests in a circular FIFO
// and retires them one per cycle whenever the register-file write port is granted.
// Also reports whether a queried register still has an unretired write queued.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   InValid/InReady         request handshake from the producer
//   InRegister/InData       destination register and data of the offered request
//   WbEnable                register-file write port granted this cycle
//   RegWrite                write strobe to the register file
//   WriteRegister/WriteData head entry (0/0 when empty)
//   QueryRegister1/2        registers being read by decode
//   Pending1/2              queried register has a queued write
//   Count                   number of valid entries
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [4:0]               InRegister,
    input  logic [31:0]              InData,
    input  logic                     WbEnable,
    output logic                     RegWrite,
    output logic [4:0]               WriteRegister,
    output logic [31:0]              WriteData,
    input  logic [4:0]               QueryRegister1,
    input  logic [4:0]               QueryRegister2,
    output logic                     Pending1,
    output logic                     Pending2,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic [DEPTH-1:0] valid;
    logic [4:0]     reg_mem  [DEPTH];
    logic [31:0]    data_mem [DEPTH];

    logic push;
    logic pop;
    logic hit1;
    logic hit2;

    always_comb begin
        InReady  = (count < (AW+1)'(DEPTH));
        RegWrite = WbEnable && (count != '0);
        // Requests to register 0 complete the handshake but are never stored.
        push     = InValid && InReady && (InRegister != 5'd0);
        pop      = RegWrite;
        Count    = count;

        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        if (count != '0) begin
            WriteRegister = reg_mem[rd_ptr];
            WriteData     = data_mem[rd_ptr];
        end

        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (reg_mem[i] == QueryRegister1)) hit1 = 1'b1;
            if (valid[i] && (reg_mem[i] == QueryRegister2)) hit2 = 1'b1;
        end
        Pending1 = hit1 && (QueryRegister1 != 5'd0);
        Pending2 = hit2 && (QueryRegister2 != 5'd0);
    end

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                rd_ptr        <= rd_ptr + AW'(1);
                valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr        <= wr_ptr + AW'(1);
                valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr]  <= InRegister;
            data_mem[wr_ptr] <= InData;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: table of per-cycle stimulus with hand-derived
// Count/InReady/RegWrite/Pending values, plus a queue of expected writes that
// is filled on accepted requests and drained as the DUT issues writes.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        WbEnable;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  QueryRegister1;
    logic [4:0]  QueryRegister2;
    logic        Pending1;
    logic        Pending2;
    logic [2:0]  Count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .InValid        (InValid),
        .InReady        (InReady),
        .InRegister     (InRegister),
        .InData         (InData),
        .WbEnable       (WbEnable),
        .RegWrite       (RegWrite),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .QueryRegister1 (QueryRegister1),
        .QueryRegister2 (QueryRegister2),
        .Pending1       (Pending1),
        .Pending2       (Pending2),
        .Count          (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        wb;
        logic [4:0]  q1;
        logic [4:0]  q2;
        int          cnt;
        logic        rdy;
        logic        rw;
        logic        p1;
        logic        p2;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    int  total = 0;
    int  bad   = 0;
    wr_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one cycle starting at a falling edge: drive, check, then advance.
    task automatic cycle(input string name, input logic v, input logic [4:0] r,
                         input logic [31:0] d, input logic wb, input logic [4:0] q1,
                         input logic [4:0] q2, input int cnt, input logic rdy,
                         input logic rw, input logic p1, input logic p2);
        wr_t e;
        InValid = v; InRegister = r; InData = d; WbEnable = wb;
        QueryRegister1 = q1; QueryRegister2 = q2;
        #1;
        chk({name, ".count"},    32'(Count),    32'(cnt));
        chk({name, ".ready"},    32'(InReady),  32'(rdy));
        chk({name, ".regwrite"}, 32'(RegWrite), 32'(rw));
        chk({name, ".pend1"},    32'(Pending1), 32'(p1));
        chk({name, ".pend2"},    32'(Pending2), 32'(p2));
        if (cnt == 0) begin
            chk({name, ".empty_wreg"},  32'(WriteRegister), 32'd0);
            chk({name, ".empty_wdata"}, WriteData,          32'd0);
        end
        if (RegWrite) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s.stray_write: got reg %0d data 0x%0h expected no write",
                         name, WriteRegister, WriteData);
            end else begin
                e = sb.pop_front();
                chk({name, ".wreg"},  32'(WriteRegister), 32'(e.r));
                chk({name, ".wdata"}, WriteData,          e.d);
            end
        end
        if (v && rdy && (r != 5'd0)) sb.push_back('{r: r, d: d});
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[25];

    initial begin
        //          v  r      d         wb q1 q2  cnt rdy rw p1 p2
        vecs[0]  = '{1, 5,  32'hAA,   1, 5, 0,  0, 1, 0, 0, 0};
        vecs[1]  = '{0, 0,  32'h0,    1, 5, 0,  1, 1, 1, 1, 0};
        vecs[2]  = '{0, 0,  32'h0,    0, 5, 0,  0, 1, 0, 0, 0};
        vecs[3]  = '{1, 1,  32'h11,   0, 1, 4,  0, 1, 0, 0, 0};
        vecs[4]  = '{1, 2,  32'h22,   0, 1, 4,  1, 1, 0, 1, 0};
        vecs[5]  = '{1, 3,  32'h33,   0, 1, 4,  2, 1, 0, 1, 0};
        vecs[6]  = '{1, 4,  32'h44,   0, 1, 4,  3, 1, 0, 1, 0};
        vecs[7]  = '{1, 9,  32'h99,   0, 1, 4,  4, 0, 0, 1, 1};
        vecs[8]  = '{0, 0,  32'h0,    1, 1, 4,  4, 0, 1, 1, 1};
        vecs[9]  = '{0, 0,  32'h0,    1, 1, 4,  3, 1, 1, 0, 1};
        vecs[10] = '{0, 0,  32'h0,    1, 1, 4,  2, 1, 1, 0, 1};
        vecs[11] = '{0, 0,  32'h0,    1, 1, 4,  1, 1, 1, 0, 1};
        vecs[12] = '{0, 0,  32'h0,    1, 1, 4,  0, 1, 0, 0, 0};
        vecs[13] = '{1, 0,  32'hDEAD, 1, 0, 0,  0, 1, 0, 0, 0};
        vecs[14] = '{0, 0,  32'h0,    1, 0, 0,  0, 1, 0, 0, 0};
        vecs[15] = '{1, 7,  32'h77,   0, 7, 8,  0, 1, 0, 0, 0};
        vecs[16] = '{0, 0,  32'h0,    0, 7, 8,  1, 1, 0, 1, 0};
        vecs[17] = '{0, 0,  32'h0,    0, 7, 8,  1, 1, 0, 1, 0};
        vecs[18] = '{0, 0,  32'h0,    1, 7, 8,  1, 1, 1, 1, 0};
        vecs[19] = '{0, 0,  32'h0,    1, 7, 8,  0, 1, 0, 0, 0};
        vecs[20] = '{1, 3,  32'hA1,   0, 3, 0,  0, 1, 0, 0, 0};
        vecs[21] = '{1, 3,  32'hA2,   0, 3, 0,  1, 1, 0, 1, 0};
        vecs[22] = '{0, 0,  32'h0,    1, 3, 0,  2, 1, 1, 1, 0};
        vecs[23] = '{0, 0,  32'h0,    1, 3, 0,  1, 1, 1, 1, 0};
        vecs[24] = '{0, 0,  32'h0,    0, 3, 0,  0, 1, 0, 0, 0};

        rst_n = 1'b0;
        InValid = 1'b1; InRegister = 5'd6; InData = 32'h66; WbEnable = 1'b1;
        QueryRegister1 = 5'd6; QueryRegister2 = 5'd0;
        @(negedge clk);
        @(negedge clk);
        // Nothing may be captured while reset is held, even with a valid offer.
        chk("reset.count",    32'(Count),    32'd0);
        chk("reset.ready",    32'(InReady),  32'd1);
        chk("reset.regwrite", 32'(RegWrite), 32'd0);
        chk("reset.pend1",    32'(Pending1), 32'd0);
        chk("reset.wreg",     32'(WriteRegister), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].wb,
                  vecs[i].q1, vecs[i].q2, vecs[i].cnt, vecs[i].rdy, vecs[i].rw,
                  vecs[i].p1, vecs[i].p2);
        end

        // Steady push+pop at Count=2 across several pointer wraps.
        cycle("wrap.fill0", 1, 10, 32'h100, 0, 10, 11, 0, 1, 0, 0, 0);
        cycle("wrap.fill1", 1, 11, 32'h101, 0, 10, 11, 1, 1, 0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            cycle($sformatf("wrap%0d", k), 1, 5'(12 + k), 32'h200 + 32'(k), 1, 0, 0,
                  2, 1, 1, 0, 0);
        end
        cycle("wrap.drain0", 0, 0, 32'h0, 1, 0, 0, 2, 1, 1, 0, 0);
        cycle("wrap.drain1", 0, 0, 32'h0, 1, 0, 0, 1, 1, 1, 0, 0);
        cycle("wrap.drain2", 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0);

        // Reset in the middle of a cycle with three writes queued.
        cycle("mid.push0", 1, 20, 32'h300, 0, 20, 22, 0, 1, 0, 0, 0);
        cycle("mid.push1", 1, 21, 32'h301, 0, 20, 22, 1, 1, 0, 1, 0);
        cycle("mid.push2", 1, 22, 32'h302, 0, 20, 22, 2, 1, 0, 1, 0);
        InValid = 1'b0; WbEnable = 1'b1;
        #1;
        chk("mid.count3",  32'(Count),    32'd3);
        chk("mid.pend1",   32'(Pending1), 32'd1);
        chk("mid.pend2",   32'(Pending2), 32'd1);
        chk("mid.rw_pre",  32'(RegWrite), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.rst_count",    32'(Count),    32'd0);
        chk("mid.rst_regwrite", 32'(RegWrite), 32'd0);
        chk("mid.rst_pend1",    32'(Pending1), 32'd0);
        chk("mid.rst_pend2",    32'(Pending2), 32'd0);
        chk("mid.rst_ready",    32'(InReady),  32'd1);
        chk("mid.rst_wdata",    WriteData,     32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle($sformatf("post_rst%0d", k), 0, 0, 32'h0, 1, 20, 22, 0, 1, 0, 0, 0);
        end

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writeback entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port InValid  input  1  producer offers a writeback request this cycle.
REQ-005 SHALL have port InReady  output  1  queue accepts a request this cycle.
REQ-006 SHALL have port InRegister  input  5  destination register of offered request.
REQ-007 SHALL have port InData  input  32  data of offered request.
REQ-008 SHALL have port WbEnable  input  1  register-file write port granted to this block this cycle.
REQ-009 SHALL have port RegWrite  output  1  write strobe to register file.
REQ-010 SHALL have port WriteRegister  output  5  register-file write address.
REQ-011 SHALL have port WriteData  output  32  register-file write data.
REQ-012 SHALL have ports QueryRegister1, QueryRegister2  input  5 each  registers being read by decode.
REQ-013 SHALL have ports Pending1, Pending2  output  1 each  queried register has an unretired write queued.
REQ-014 SHALL have port Count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL store requests as a circular FIFO: read pointer, write pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-016 SHALL drive InReady = (Count < DEPTH); it SHALL NOT depend on WbEnable (no full-queue pass-through).
REQ-017 SHALL treat InValid && InReady at a rising edge as an accepted request.
REQ-018 SHALL enqueue an accepted request at the write pointer only if InRegister != 0; a request to register 0 SHALL be accepted and discarded, leaving Count unchanged.
REQ-019 SHALL drive RegWrite = WbEnable && (Count != 0), combinationally.
REQ-020 SHALL drive WriteRegister/WriteData from the head entry whenever Count != 0, and 0/0 when empty.
REQ-021 SHALL pop the head entry at each rising edge where RegWrite = 1.
REQ-022 SHALL, on simultaneous enqueue and pop in one edge, leave Count unchanged and advance both pointers.
REQ-023 SHALL retire entries strictly in acceptance order; two entries to the same register SHALL both be written, older first.
REQ-024 SHALL give minimum latency of one cycle: request accepted at edge N into an empty queue appears on RegWrite in the cycle after edge N, when WbEnable is high.
REQ-025 SHALL drive PendingX = 1 when QueryRegisterX != 0 and matches InRegister of any valid entry (head included); combinational over current state only; the offered, not-yet-accepted request SHALL NOT count.
REQ-026 SHALL drive PendingX = 0 for QueryRegisterX = 0 under all conditions.
REQ-027 SHALL hold all state unchanged while WbEnable = 0 and no request is accepted.
REQ-028 SHALL never overflow or underflow; Count SHALL remain within 0..DEPTH.

Reset
REQ-029 SHALL, while rst_n = 0, immediately clear pointers and Count to 0, invalidate all entries, and force RegWrite = 0, WriteRegister = 0, WriteData = 0, Pending1/2 = 0, InReady = 1.
REQ-030 SHALL discard queued, unretired writes on reset mid-operation; no write is issued after rst_n deasserts until a new request is accepted.
REQ-031 SHALL not require entry data storage to be reset; only valid state is reset.

Verification
REQ-032 Push reg 5/0x0000_00AA with WbEnable=1 into an empty queue -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xAA; following cycle Count=0.
REQ-033 WbEnable=0, push regs 1,2,3,4 with data 0x11..0x44 -> Count=4, InReady=0, fifth InValid is not accepted; then WbEnable=1 -> four writes in order 1,2,3,4, one per cycle, InReady=1 after the first pop.
REQ-034 Push reg 0/0xDEAD -> InReady=1, accepted, Count stays 0, RegWrite never asserted, Pending for query 0 = 0.
REQ-035 WbEnable=0, queue holds reg 7 -> QueryRegister1=7 gives Pending1=1, QueryRegister2=8 gives Pending2=0; after reg 7 retires, Pending1=0.
REQ-036 Count=2, simultaneous accepted push and pop -> Count stays 2, pointers wrap past DEPTH-1 correctly across 10 such cycles, data order preserved.
REQ-037 Count=3, assert rst_n=0 mid-cycle -> RegWrite, Count, Pending1/2 go to 0 without waiting for a clock edge; after release, no stale writes issue.
